pow2_serial: RTL and testbench



---
 rtl/pow2_serial_pkg.sv | 9 +
 rtl/pow2_serial_if.sv | 34 +++
 rtl/pow2_serial.sv | 72 +++++++
 tb/tb_pow2_serial.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pow2_serial_pkg.sv
// pow2_serial_pkg: shared widths, state encoding and vector types for pow2_serial.
// Contents: EXP_W/OUT_W defaults, state_t {IDLE, SHIFT, DONE}, exp_t, res_t.
package pow2_pkg;
    localparam int EXP_W = 3;
    localparam int OUT_W = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef logic [EXP_W-1:0] exp_t;
    typedef logic [OUT_W-1:0] res_t;
endpackage

// File: rtl/pow2_serial_if.sv
// pow2_serial_if: valid/ready bundle between an exponent producer and a linear-value consumer.
// Signals: in_valid/in_ready/in_exp (request), out_valid/out_ready/out_data (result), busy.
// With POW2_SERIAL_SCALE_EN defined: in_base (start value) and out_ovf (bits lost off the top).
// Modports: slave (the pow2_serial block), master (the producer/consumer side).
interface pow2_serial_if;
    import pow2_pkg::*;
    logic in_valid;
    logic in_ready;
    exp_t in_exp;
    logic out_valid;
    logic out_ready;
    res_t out_data;
    logic busy;
`ifdef POW2_SERIAL_SCALE_EN
    res_t in_base;
    logic out_ovf;
`endif
    modport slave (
        input  in_valid, in_exp, out_ready,
`ifdef POW2_SERIAL_SCALE_EN
        input  in_base,
        output out_ovf,
`endif
        output in_ready, out_valid, out_data, busy
    );
    modport master (
        output in_valid, in_exp, out_ready,
`ifdef POW2_SERIAL_SCALE_EN
        output in_base,
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/pow2_serial.sv
// pow2_serial: iterative 2^e generator, one left shift per cycle, valid/ready on both sides.
// Ports: clk (rising edge), rst_n (async, active-low), bus (pow2_serial_if.slave).
// Optional POW2_SERIAL_SCALE_EN: start from bus.in_base instead of 1 and flag shifted-out ones on out_ovf.
module pow2_serial
    import pow2_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    pow2_serial_if.slave bus
);
    state_t state_q, state_d;
    res_t   acc_q, acc_d;
    exp_t   cnt_q, cnt_d;
    res_t   base;
`ifdef POW2_SERIAL_SCALE_EN
    logic   ovf_q, ovf_d;
    assign base = bus.in_base;
    assign bus.out_ovf = ovf_q;
`else
    assign base = res_t'(1);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef POW2_SERIAL_SCALE_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef POW2_SERIAL_SCALE_EN
            ovf_q   <= ovf_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef POW2_SERIAL_SCALE_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                acc_d   = base;
                cnt_d   = bus.in_exp;
                // e==0 needs no shift, so the result is ready on the accept edge
                state_d = (bus.in_exp == '0) ? DONE : SHIFT;
`ifdef POW2_SERIAL_SCALE_EN
                ovf_d   = 1'b0;
`endif
            end
            SHIFT: begin
                acc_d   = acc_q << 1;
                cnt_d   = cnt_q - exp_t'(1);
                state_d = (cnt_q == exp_t'(1)) ? DONE : SHIFT;
`ifdef POW2_SERIAL_SCALE_EN
                ovf_d   = ovf_q | acc_q[OUT_W-1];
`endif
            end
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = acc_q;
endmodule

// File: tb/tb_pow2_serial.sv
// tb_pow2_serial: directed bench for pow2_serial with a floor-log2 round-trip reference.
module tb_pow2_serial;
    import pow2_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    pow2_serial_if bus();
    pow2_serial dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic int flog2(input res_t v);
        int r = -1;
        for (int i = 0; i < OUT_W; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic send(input int e, input res_t base, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_exp = exp_t'(e);
`ifdef POW2_SERIAL_SCALE_EN
        bus.in_base = base;
`else
        if (base != res_t'(1)) $display("note: base ignored in this build");
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = 99;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h busy=%b, want 1 0 00 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.busy);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        int lat;
        res_t exp_v;
        bus.out_ready = 1'b1;
        for (int e = 0; e < OUT_W; e++) begin
            exp_v = res_t'(1) << e;
            send(e, res_t'(1), lat);
            n_checks++;
            if (lat !== e + 1) begin
                n_fail++;
                $display("FAIL sweep_latency e=%0d: got %0d want %0d", e, lat, e + 1);
            end
            n_checks++;
            if (bus.out_data !== exp_v) begin
                n_fail++;
                $display("FAIL sweep_data e=%0d: got %h want %h", e, bus.out_data, exp_v);
            end
            n_checks++;
            if (flog2(bus.out_data) !== e) begin
                n_fail++;
                $display("FAIL sweep_roundtrip e=%0d: log2 got %0d", e, flog2(bus.out_data));
            end
            @(posedge clk); #1;
            n_checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_release e=%0d: in_ready=%b out_valid=%b want 1 0", e, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        send(3, res_t'(1), lat);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d want 4", lat);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h08 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b out_data=%h in_ready=%b want 1 08 0",
                         c, bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        @(negedge clk) bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        int extra = 0;
        bus.out_ready = 1'b0;
        fork
            send(6, res_t'(1), lat);
            begin
                @(posedge clk); #2;
                repeat (4) begin
                    @(negedge clk);
                    bus.in_valid = ~bus.in_valid;
                    bus.in_exp = exp_t'(2);
                end
                bus.in_valid = 1'b0;
            end
        join
        n_checks++;
        if (lat !== 7 || bus.out_data !== 8'h40) begin
            n_fail++;
            $display("FAIL ignore_busy_result: lat=%0d data=%h want 7 40", lat, bus.out_data);
        end
        @(negedge clk) bus.out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL ignore_busy_single: %0d extra busy/valid cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_exp = exp_t'(7);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b out_data=%h busy=%b want 1 0 00 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.busy);
        end
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(1, res_t'(1), lat);
        n_checks++;
        if (lat !== 2 || bus.out_data !== 8'h02) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: lat=%0d data=%h want 2 02", lat, bus.out_data);
        end
        @(posedge clk); #1;
    endtask

`ifdef POW2_SERIAL_SCALE_EN
    task automatic test_scale();
        int lat;
        bus.out_ready = 1'b1;
        send(2, 8'h03, lat);
        n_checks++;
        if (lat !== 3 || bus.out_data !== 8'h0C || bus.out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL scale_03_e2: lat=%0d data=%h ovf=%b want 3 0C 0", lat, bus.out_data, bus.out_ovf);
        end
        @(posedge clk); #1;
        send(1, 8'hC0, lat);
        n_checks++;
        if (lat !== 2 || bus.out_data !== 8'h80 || bus.out_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL scale_C0_e1: lat=%0d data=%h ovf=%b want 2 80 1", lat, bus.out_data, bus.out_ovf);
        end
        @(posedge clk); #1;
        send(4, 8'h00, lat);
        n_checks++;
        if (lat !== 5 || bus.out_data !== 8'h00 || bus.out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL scale_00_e4: lat=%0d data=%h ovf=%b want 5 00 0", lat, bus.out_data, bus.out_ovf);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_exp = '0;
        bus.out_ready = 1'b0;
`ifdef POW2_SERIAL_SCALE_EN
        bus.in_base = 8'h01;
`endif
        test_reset();
        test_sweep();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid();
`ifdef POW2_SERIAL_SCALE_EN
        test_scale();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
